// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared state encoding, default width and product-width helper
package seq_mult_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 16;

    function automatic int prod_w(input int w);
        return 2 * w;
    endfunction
endpackage

// File: rtl/seq_shift_add_mult_adder.sv
// seq_shift_add_mult_adder: full-adder cell and the N-bit ripple chain built from it
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module ripple_adder_n #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    logic [N:0] w_c;

    assign w_c[0] = cin;
    assign cout   = w_c[N];

    for (genvar i = 0; i < N; i++) begin : g_fa
        full_adder u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (w_c[i]),
            .sum (sum[i]),
            .cout(w_c[i+1])
        );
    end
endmodule

// File: rtl/seq_shift_add_mult.sv
// seq_shift_add_mult: sequential shift-and-add multiplier, one partial product per clock.
// Define SIGNED_MULT_EN to honour is_signed (two's-complement via magnitudes and final negate).
module seq_shift_add_mult
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           mcand,
    input  logic [WIDTH-1:0]           mplier,
    input  logic                       is_signed,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [prod_w(WIDTH)-1:0]   product,
    output logic                       busy
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam int PW    = prod_w(WIDTH);

    state_t             r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_mcand;
    logic [PW-1:0]      r_acc;

    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_m_in;
    logic [WIDTH-1:0]   w_q_in;
    logic               w_cout;
    logic               w_last;
    logic [PW-1:0]      w_next;
    logic [PW-1:0]      w_fin;

    // Masking M with acc[0] turns the conditional add into an unconditional one.
    ripple_adder_n #(.N(WIDTH)) u_add (
        .a   (r_acc[PW-1:WIDTH]),
        .b   (r_mcand & {WIDTH{r_acc[0]}}),
        .cin (1'b0),
        .sum (w_sum),
        .cout(w_cout)
    );

    assign w_next = {w_cout, w_sum, r_acc[WIDTH-1:1]};
    assign w_last = r_cnt == CNT_W'(WIDTH - 1);

`ifdef SIGNED_MULT_EN
    logic r_neg;

    assign w_m_in = (is_signed && mcand[WIDTH-1])  ? ~mcand + WIDTH'(1)  : mcand;
    assign w_q_in = (is_signed && mplier[WIDTH-1]) ? ~mplier + WIDTH'(1) : mplier;
    assign w_fin  = r_neg ? ~w_next + PW'(1) : w_next;

    always_ff @(posedge clk) begin
        if (rst)
            r_neg <= 1'b0;
        else if (r_state == IDLE && in_valid)
            r_neg <= is_signed && (mcand[WIDTH-1] ^ mplier[WIDTH-1]);
    end
`else
    logic w_unused;

    assign w_unused = is_signed;
    assign w_m_in   = mcand;
    assign w_q_in   = mplier;
    assign w_fin    = w_next;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_cnt       <= '0;
            r_mcand     <= '0;
            r_acc       <= '0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_mcand    <= w_m_in;
                    r_acc      <= {{WIDTH{1'b0}}, w_q_in};
                    r_cnt      <= '0;
                    r_state    <= BUSY;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b1;
                end
                BUSY: begin
                    r_acc <= w_last ? w_fin : w_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state     <= DONE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign product   = r_acc;
endmodule

// File: tb/tb_seq_shift_add_mult.sv
// tb_seq_shift_add_mult: directed and randomised vectors against a queued expected-product scoreboard
module tb_seq_shift_add_mult;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] mcand = '0;
    logic [15:0] mplier = '0;
    logic        is_signed = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] product;
    logic        busy;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] sb[$];

    seq_shift_add_mult #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mcand    (mcand),
        .mplier   (mplier),
        .is_signed(is_signed),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .product  (product),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Monitor: every completed output transfer consumes exactly one expected product.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_product act=%h exp=none", product);
            end else
                check("product", product, sb.pop_front());
        end
    end

    task automatic send(input logic [15:0] m, input logic [15:0] q, input logic s,
                        input bit push, input logic [31:0] exp, input bit rnd);
        int n = 0;
        mcand = m;
        mplier = q;
        is_signed = s;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        if (push) sb.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        int          lat;
        logic [15:0] m, q;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_product", product, 0);
        rst = 1'b0;

        send(16'd3, 16'd5, 1'b0, 1, 32'h0000_000F, 0);
        check("busy_after_accept", busy, 1);
        check("in_ready_busy", in_ready, 0);
        wait_valid(lat);
        check("latency_3x5", lat, 16);
        @(posedge clk); #1;
        check("in_ready_after_done", in_ready, 1);
        check("out_valid_after_done", out_valid, 0);

        send(16'hFFFF, 16'hFFFF, 1'b0, 1, 32'hFFFE_0001, 0);
        send(16'h0000, 16'hABCD, 1'b0, 1, 32'h0000_0000, 0);
        send(16'hFFFF, 16'h0001, 1'b0, 1, 32'h0000_FFFF, 0);
        send(16'h8000, 16'h0002, 1'b0, 1, 32'h0001_0000, 0);
`ifdef SIGNED_MULT_EN
        send(16'hFFFD, 16'h0005, 1'b1, 1, 32'hFFFF_FFF1, 0);
        send(16'h8000, 16'h8000, 1'b1, 1, 32'h4000_0000, 0);
        send(16'h8000, 16'h0003, 1'b1, 1, 32'hFFFE_8000, 0);
`else
        send(16'hFFFD, 16'h0005, 1'b1, 1, 32'h0004_FFF1, 0);
        send(16'h8000, 16'h8000, 1'b1, 1, 32'h4000_0000, 0);
        send(16'h8000, 16'h0003, 1'b1, 1, 32'h0001_8000, 0);
`endif
        send(16'hFFFD, 16'h0005, 1'b0, 1, 32'h0004_FFF1, 0);
        wait_valid(lat);
        @(posedge clk); #1;

        out_ready = 1'b0;
        send(16'h1234, 16'h5678, 1'b0, 1, 32'h0626_0060, 0);
        wait_valid(lat);
        for (int i = 0; i < 10; i++) begin
            mcand = 16'd7;
            mplier = 16'd7;
            in_valid = 1'b1;
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_product", product, 32'h0626_0060);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", out_valid, 0);
        check("bp_release_ready", in_ready, 1);

        send(16'd100, 16'd200, 1'b0, 0, 32'h0, 0);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_product", product, 0);
        send(16'd7, 16'd9, 1'b0, 1, 32'd63, 0);
        wait_valid(lat);
        check("latency_7x9", lat, 16);
        @(posedge clk); #1;

        for (int i = 0; i < 100; i++) begin
            m = 16'($urandom);
            q = 16'($urandom);
            send(m, q, 1'b0, 1, {16'b0, m} * {16'b0, q}, 1);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_empty", sb.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        check("final_idle", in_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
